vc_priority_encoder_32: RTL and testbench
=========================================

Name: vc_priority_encoder_32

Overview:
32-bit to 5-bit priority encoder block providing both encodings of the same input:
- **Forward:** index of the highest set bit.
- **Reverse:** index of the lowest set bit.

Both results are available combinationally, for same-cycle arbitration and find-first-set logic. Registered copies are also provided for pipelined consumers. The block is used by arbiters, free-list allocators and leading-one detection in the datapath.

Parameters:
- None. Input width is fixed at 32 and index width at 5.

Ports:
- clk  input  1  Clock; rising-edge active.
- reset  input  1  Asynchronous, active-high reset for the registered outputs.
- in_bits  input  32  Request/bit vector to encode.
- out_val  output  1  Combinational; 1 iff in_bits != 0.
- out_bits  output  5  Combinational; index of highest set bit of in_bits.
- rev_out_val  output  1  Combinational; 1 iff in_bits != 0.
- rev_out_bits  output  5  Combinational; index of lowest set bit of in_bits.
- reg_out_val  output  1  out_val registered on clk.
- reg_out_bits  output  5  out_bits registered on clk.
- reg_rev_out_val  output  1  rev_out_val registered on clk.
- reg_rev_out_bits  output  5  rev_out_bits registered on clk.

Behaviour:
- **Combinational path, zero latency:** outputs settle within the same cycle as in_bits changes. They do not depend on clk or reset.
- **out_val / rev_out_val:** OR-reduction of in_bits. The two are always equal.
- **out_bits:** largest i such that in_bits[i] == 1.
  - Examples: 32'h80000000 -> 31; 32'hffffffff -> 31; 32'h0010dead -> 20; 32'h00000001 -> 0.
- **rev_out_bits:** smallest i such that in_bits[i] == 1.
  - Examples: 32'h80000000 -> 31; 32'hf0000000 -> 28; 32'hffffffff -> 0; 32'hf0f0f000 -> 12.
- **Empty input (in_bits == 0):** out_val = rev_out_val = 0, and out_bits = rev_out_bits = 5'd0.
  - Consumers must qualify the index with the valid flag.
  - The zero-drive is fixed so that X never propagates.
- **Single-bit input:** forward and reverse indices are identical.
- **Registered path:** on each rising clk edge, the four reg_* outputs capture their combinational counterparts.
  - Latency is exactly 1 cycle.
  - There is no enable; the registers capture every cycle.
- **Reset:** asserting reset immediately forces all reg_* outputs to 0, asynchronously and without waiting for a clock edge.
  - They hold 0 while reset is high.
  - On the first rising edge after reset deasserts, they capture normally.
  - Reset mid-operation discards the captured value; combinational outputs are unaffected.
- **Structure:** no state other than the four output registers. No X-generating logic: no casez defaults with don't-care outputs and no latches.

Decomposition:
- **Shared package:** constants NBITS = 32 and NIDX = 5 (clog2 of NBITS), plus an index typedef of width NIDX.
- **Sub-module: vc_pri_enc_core.**
  - Combinational highest-set-bit encoder, 32 -> {valid, 5-bit idx}.
  - Built as a log-depth tree of 2:1 priority merges; a flat loop is also acceptable.
  - Instantiated twice:
    - once on in_bits directly (forward);
    - once on bit-reversed in_bits, with result idx mapped to 31 - idx (reverse). The empty-case result must still be 0.
- The top level adds only the reverse wiring and the output registers.

Test Plan:
- **Forward combinational sweep:** apply each input, wait 1 time unit, check out_val/out_bits.
  - 00000000 -> 0 / 0
  - 80000000 -> 1 / 31
  - f0000000 -> 1 / 31
  - 01000000 -> 1 / 24
  - 00001000 -> 1 / 12
  - 10000001 -> 1 / 28
  - 00000001 -> 1 / 0
- **Reverse combinational sweep:** check rev_out_val/rev_out_bits.
  - 00000000 -> 0 / 0
  - 80000000 -> 1 / 31
  - ffffffff -> 1 / 0
  - 00100000 -> 1 / 20
  - 0010dead -> 1 / 0
  - dead0010 -> 1 / 4
- **Exhaustive one-hot and two-hot:** for all i, and all i > j pairs:
  - 1<<i -> both indices = i;
  - (1<<i) | (1<<j) -> forward = i, reverse = j.
- **Registered latency:**
  - Drive 32'h0010dead before edge N -> after edge N, reg_out_bits = 20 and reg_rev_out_bits = 0.
  - Change the input to 32'h00000000 -> the reg outputs remain 20/0 until edge N+1, then become 0/0 with reg valids = 0.
- **Asynchronous reset:** with reg outputs holding 31/28 (input f0000000), raise reset between edges.
  - All reg_* outputs read 0 before the next edge.
  - They stay 0 across edges while reset is high.
  - They recapture the current input on the first edge after deassertion.
- **Random compare:** 10k random 32-bit vectors, including sparse ones, against behavioural highest/lowest-set-bit models, for both combinational and 1-cycle-delayed registered outputs.

Source files
------------

// File: rtl/vc_priority_encoder_32_pkg.sv
// Shared constants and index type for the 32-bit priority encoder slice.
package vc_priority_encoder_32_pkg;
  localparam int NBITS = 32;
  localparam int NIDX  = $clog2(NBITS);

  typedef logic [NIDX-1:0] idx_t;
endpackage

// File: rtl/vc_pri_enc_core.sv
// Combinational highest-set-bit encoder built as a log-depth tree of 2:1 priority merges.
module vc_pri_enc_core
  import vc_priority_encoder_32_pkg::*;
(
  input  logic [NBITS-1:0] in_bits,
  output logic             valid,
  output idx_t             idx
);

  // Heap-ordered tree: node 1 is the root, node n has children 2n (low half)
  // and 2n+1 (high half), and leaves NBITS..2*NBITS-1 map to in_bits[0..NBITS-1].
  logic [2*NBITS-1:1] node_v;
  idx_t               node_idx [1:2*NBITS-1];

  genvar gi, gl;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_leaf
      assign node_v[NBITS+gi]   = in_bits[gi];
      assign node_idx[NBITS+gi] = '0;
    end

    for (gl = 0; gl < NIDX; gl++) begin : g_lvl
      for (gi = 0; gi < (1 << gl); gi++) begin : g_node
        localparam int N  = (1 << gl) + gi;
        localparam int HB = NIDX - 1 - gl;
        assign node_v[N] = node_v[2*N] | node_v[2*N+1];
        // High half wins; an empty subtree falls through to the low child, so
        // an all-zero input resolves to index 0 rather than anything undefined.
        assign node_idx[N] = node_v[2*N+1] ? (node_idx[2*N+1] | idx_t'(1 << HB))
                                           : node_idx[2*N];
      end
    end
  endgenerate

  assign valid = node_v[1];
  assign idx   = node_idx[1];

endmodule

// File: rtl/vc_priority_encoder_32.sv
// Forward (highest set bit) and reverse (lowest set bit) encodings of a 32-bit
// vector, available combinationally and as 1-cycle registered copies.
module vc_priority_encoder_32
  import vc_priority_encoder_32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in_bits,
  output logic             out_val,
  output logic [NIDX-1:0]  out_bits,
  output logic             rev_out_val,
  output logic [NIDX-1:0]  rev_out_bits,
  output logic             reg_out_val,
  output logic [NIDX-1:0]  reg_out_bits,
  output logic             reg_rev_out_val,
  output logic [NIDX-1:0]  reg_rev_out_bits
);

  logic [NBITS-1:0] rev_in;
  idx_t             rev_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_rev
      assign rev_in[gi] = in_bits[NBITS-1-gi];
    end
  endgenerate

  vc_pri_enc_core u_fwd (
    .in_bits (in_bits),
    .valid   (out_val),
    .idx     (out_bits)
  );

  vc_pri_enc_core u_rev (
    .in_bits (rev_in),
    .valid   (rev_out_val),
    .idx     (rev_idx)
  );

  // Highest bit of the mirrored vector is the lowest bit of the original;
  // gate on valid so the empty case stays 0 instead of mapping to 31.
  assign rev_out_bits = rev_out_val ? (idx_t'(NBITS - 1) - rev_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_out_val      <= 1'b0;
      reg_out_bits     <= '0;
      reg_rev_out_val  <= 1'b0;
      reg_rev_out_bits <= '0;
    end else begin
      reg_out_val      <= out_val;
      reg_out_bits     <= out_bits;
      reg_rev_out_val  <= rev_out_val;
      reg_rev_out_bits <= rev_out_bits;
    end
  end

endmodule

// File: tb/tb_vc_priority_encoder_32.sv
// Scoreboard bench: stimulus pushes expected registered results, a monitor pops
// and compares them after each rising edge; combinational outputs checked inline.
module tb_vc_priority_encoder_32;

  typedef struct {
    logic        v;
    logic [4:0]  f;
    logic [4:0]  r;
    logic [31:0] vec;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] in_bits;
  logic        out_val, rev_out_val, reg_out_val, reg_rev_out_val;
  logic [4:0]  out_bits, rev_out_bits, reg_out_bits, reg_rev_out_bits;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;
  exp_t sb_q[$];

  vc_priority_encoder_32 dut (
    .clk              (clk),
    .reset            (reset),
    .in_bits          (in_bits),
    .out_val          (out_val),
    .out_bits         (out_bits),
    .rev_out_val      (rev_out_val),
    .rev_out_bits     (rev_out_bits),
    .reg_out_val      (reg_out_val),
    .reg_out_bits     (reg_out_bits),
    .reg_rev_out_val  (reg_rev_out_val),
    .reg_rev_out_bits (reg_rev_out_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan every bit; the last set bit seen going up is the highest,
  // the last set bit seen going down is the lowest.
  function automatic exp_t model(logic [31:0] x);
    exp_t e;
    e.vec = x;
    e.v   = (x != 32'd0);
    e.f   = 5'd0;
    e.r   = 5'd0;
    for (int i = 0; i < 32; i++) if (x[i]) e.f = 5'(i);
    for (int i = 31; i >= 0; i--) if (x[i]) e.r = 5'(i);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (in=%h t=%0t)", name, act, exp, in_bits, $time);
    end
  endtask

  task automatic check_comb(logic [31:0] x);
    exp_t e;
    e = model(x);
    chk("out_val",      32'(out_val),      32'(e.v));
    chk("out_bits",     32'(out_bits),     32'(e.f));
    chk("rev_out_val",  32'(rev_out_val),  32'(e.v));
    chk("rev_out_bits", 32'(rev_out_bits), 32'(e.r));
  endtask

  task automatic check_regs_zero(string tag);
    chk({tag, ".reg_out_val"},      32'(reg_out_val),      32'd0);
    chk({tag, ".reg_out_bits"},     32'(reg_out_bits),     32'd0);
    chk({tag, ".reg_rev_out_val"},  32'(reg_rev_out_val),  32'd0);
    chk({tag, ".reg_rev_out_bits"}, 32'(reg_rev_out_bits), 32'd0);
  endtask

  // Apply a vector (and reset level) after a falling edge, check the
  // combinational path, and queue what the registers must show after the next rise.
  task automatic drive(logic [31:0] x, logic r);
    exp_t e;
    @(negedge clk);
    reset   = r;
    in_bits = x;
    #1;
    check_comb(x);
    e = model(x);
    if (r) begin
      e.v = 1'b0;
      e.f = 5'd0;
      e.r = 5'd0;
    end
    sb_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        #1;
        n_txn++;
        $display("txn %0d in=%h reg=%0d/%0d rev=%0d/%0d exp=%0d/%0d rev=%0d/%0d",
                 n_txn, e.vec, reg_out_val, reg_out_bits, reg_rev_out_val, reg_rev_out_bits,
                 e.v, e.f, e.v, e.r);
        chk("reg_out_val",      32'(reg_out_val),      32'(e.v));
        chk("reg_out_bits",     32'(reg_out_bits),     32'(e.f));
        chk("reg_rev_out_val",  32'(reg_rev_out_val),  32'(e.v));
        chk("reg_rev_out_bits", 32'(reg_rev_out_bits), 32'(e.r));
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] dir_vec [12];
    logic [31:0] x;
    exp_t        e;

    dir_vec = '{32'h00000000, 32'h80000000, 32'hf0000000, 32'h01000000,
                32'h00001000, 32'h10000001, 32'h00000001, 32'hffffffff,
                32'h00100000, 32'h0010dead, 32'hdead0010, 32'hf0f0f000};

    reset   = 1'b1;
    in_bits = 32'h0;
    #1;
    check_regs_zero("reset_state");

    drive(32'hffffffff, 1'b1);
    drive(32'h80000000, 1'b1);

    foreach (dir_vec[k]) drive(dir_vec[k], 1'b0);

    for (int i = 0; i < 32; i++) drive(32'd1 << i, 1'b0);
    for (int i = 1; i < 32; i++)
      for (int j = 0; j < i; j++)
        drive((32'd1 << i) | (32'd1 << j), 1'b0);

    // Registered latency: value holds until the next edge after the input changes.
    drive(32'h0010dead, 1'b0);
    @(negedge clk);
    in_bits = 32'h00000000;
    #1;
    chk("latency.hold_fwd", 32'(reg_out_bits),     32'd20);
    chk("latency.hold_rev", 32'(reg_rev_out_bits), 32'd0);
    check_comb(32'h0);
    sb_q.push_back(model(32'h0));

    // Asynchronous reset raised between edges.
    drive(32'hf0000000, 1'b0);
    @(negedge clk);
    e.vec = in_bits; e.v = 1'b0; e.f = 5'd0; e.r = 5'd0;
    sb_q.push_back(e);
    chk("pre_reset.fwd", 32'(reg_out_bits),     32'd31);
    chk("pre_reset.rev", 32'(reg_rev_out_bits), 32'd28);
    #2;
    reset = 1'b1;
    #1;
    check_regs_zero("async_reset");
    check_comb(32'hf0000000);
    drive(32'hf0000000, 1'b1);
    drive(32'hf0000000, 1'b1);
    drive(32'hf0000000, 1'b0);

    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0:       x = $urandom();
        1:       x = $urandom() & $urandom() & $urandom();
        2:       x = 32'd1 << $urandom_range(0, 31);
        default: x = ($urandom_range(0, 7) == 0) ? 32'd0
                   : ((32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31)));
      endcase
      drive(x, 1'b0);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
